// File: rtl/wisc_pkg.sv
// Shared WISC definitions used by the EX/MEM boundary logic.
//   - 4-bit opcode constants for the full WISC instruction set
//   - bit positions of N/Z/V inside any 3-bit {N,Z,V} flag vector
//   - opcode classifiers that say which flags an instruction writes
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LLB    = 4'b1010;
   localparam logic [3:0] OP_LHB    = 4'b1011;
   localparam logic [3:0] OP_B      = 4'b1100;
   localparam logic [3:0] OP_BR     = 4'b1101;
   localparam logic [3:0] OP_PCS    = 4'b1110;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   localparam int FLG_N = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_V = 0;

   // ADD and SUB write N, Z and V.
   function automatic logic sets_all_flags(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // Logical and shift ops write only Z; N and V keep their old values.
   function automatic logic sets_z_only(input logic [3:0] op);
      return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/flag_reg.sv
// Three-bit architectural flag register with an independent write enable
// per bit, so Z-only instructions can update Z while N and V hold.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears all flags
//   we     per-bit write enables
//   d      per-bit next values
//   q      registered flags
module flag_reg (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] we,
   input  logic [2:0] d,
   output logic [2:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (we[i]) q[i] <= d[i];
         end
      end
   end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline boundary for the WISC 16-bit core.
// Registers the EX result, destination and control into MEM, owns the
// architectural N/Z/V flags and provides a same-cycle flag bypass for
// branch resolution.
//
// Pipeline control semantics (single place this is described):
//   ex_valid marks a real instruction in EX. The stage advances whenever
//   stall is low. Priority is rst_n > stall > flush > normal. A stall holds
//   every register including the flags. A flush (without stall) inserts a
//   bubble: mem_valid and all MEM control bits go low and flags hold; data
//   registers still load but carry no meaning. MEM control outputs are
//   always qualified by mem_valid.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   stall, flush                pipeline hold / bubble insertion
//   ex_valid, ex_opcode         EX instruction presence and opcode
//   ex_result, ex_ovfl          EX result (already saturated) and overflow
//   ex_rd, ex_reg_write         destination register and its write enable
//   ex_mem_read, ex_mem_write   load / store
//   ex_store_data               store data
//   mem_*                       registered copies for the MEM stage
//   flag_n, flag_z, flag_v      architectural flags
//   flags_fwd                   {N,Z,V} as they will be after this edge
module ex_mem_flag_stage
   import wisc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [3:0]        ex_opcode,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              ex_ovfl,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [DATA_W-1:0] ex_store_data,
   output logic              mem_valid,
   output logic [3:0]        mem_opcode,
   output logic [DATA_W-1:0] mem_result,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [REG_AW-1:0] mem_rd,
   output logic              mem_reg_write,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic              flag_n,
   output logic              flag_z,
   output logic              flag_v,
   output logic [2:0]        flags_fwd
);

   logic       adv;
   logic       take;        // a real instruction enters MEM this edge
   logic       flag_upd;
   logic [2:0] flag_we;
   logic [2:0] flag_d;
   logic [2:0] flag_q;

   assign adv      = ~stall;
   assign take     = ex_valid & ~flush;
   assign flag_upd = adv & take;

   // ---------------- pipeline register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_valid      <= 1'b0;
         mem_opcode     <= 4'd0;
         mem_result     <= '0;
         mem_store_data <= '0;
         mem_rd         <= '0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
      end else if (adv) begin
         mem_valid      <= take;
         mem_opcode     <= ex_opcode;
         mem_result     <= ex_result;
         mem_store_data <= ex_store_data;
         mem_rd         <= ex_rd;
         mem_reg_write  <= ex_reg_write & take;
         mem_mem_read   <= ex_mem_read  & take;
         mem_mem_write  <= ex_mem_write & take;
      end
   end

   // ---------------- flag update decode ----------------
   // Z is taken from the saturated result, so a saturated 0x7FFF with V=1
   // still reports Z=0.
   always_comb begin
      flag_d         = 3'b000;
      flag_d[FLG_N]  = ex_result[DATA_W-1];
      flag_d[FLG_Z]  = (ex_result == '0);
      flag_d[FLG_V]  = ex_ovfl;

      flag_we        = 3'b000;
      flag_we[FLG_N] = flag_upd & sets_all_flags(ex_opcode);
      flag_we[FLG_Z] = flag_upd & (sets_all_flags(ex_opcode) | sets_z_only(ex_opcode));
      flag_we[FLG_V] = flag_upd & sets_all_flags(ex_opcode);
   end

   flag_reg u_flag_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (flag_we),
      .d     (flag_d),
      .q     (flag_q)
   );

   // Bypass: the value each flag bit will hold after this edge.
   always_comb begin
      flags_fwd = flag_q;
      for (int i = 0; i < 3; i++) begin
         if (flag_we[i]) flags_fwd[i] = flag_d[i];
      end
   end

   assign flag_n = flag_q[FLG_N];
   assign flag_z = flag_q[FLG_Z];
   assign flag_v = flag_q[FLG_V];

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
module tb_ex_mem_flag_stage;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n, stall, flush, ex_valid, ex_ovfl;
   logic [3:0]  ex_opcode, ex_rd;
   logic [15:0] ex_result, ex_store_data;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;
   logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
   logic [3:0]  mem_opcode, mem_rd;
   logic [15:0] mem_result, mem_store_data;
   logic        flag_n, flag_z, flag_v;
   logic [2:0]  flags_fwd;

   always #5 clk = ~clk;

   ex_mem_flag_stage #(.DATA_W(16), .REG_AW(4)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
      .ex_ovfl(ex_ovfl), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_store_data(ex_store_data),
      .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_result(mem_result),
      .mem_store_data(mem_store_data), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write),
      .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flags_fwd(flags_fwd)
   );

   // ---------------- check task ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   // Record layout: {valid, opcode, result, store, rd, rw, mr, mw, N, Z, V}
   logic [46:0] exp_q[$];

   logic        m_valid, m_rw, m_mr, m_mw, m_known;
   logic [3:0]  m_op, m_rd;
   logic [15:0] m_res, m_sd;
   logic [2:0]  m_flg;   // {N,Z,V}

   // Flags the architecture says will hold after this edge.
   function automatic logic [2:0] model_next_flags();
      logic [2:0] nf;
      nf = m_flg;
      if (!stall && !flush && ex_valid) begin
         case (ex_opcode)
            4'd0, 4'd1:             nf = {ex_result[15], ex_result == 16'h0, ex_ovfl};
            4'd2, 4'd4, 4'd5, 4'd6: nf[1] = (ex_result == 16'h0);
            default:                nf = m_flg;
         endcase
      end
      return nf;
   endfunction

   function automatic logic [46:0] model_rec();
      logic [15:0] r, s;
      logic [3:0]  o, d;
      r = m_known ? m_res : 16'h0;
      s = m_known ? m_sd  : 16'h0;
      o = m_known ? m_op  : 4'h0;
      d = m_known ? m_rd  : 4'h0;
      return {m_valid, o, r, s, d, m_rw, m_mr, m_mw, m_flg};
   endfunction

   // Data fields after a flush are meaningless, so they are masked the
   // same way the expected record masks them.
   function automatic logic [46:0] dut_rec();
      logic [15:0] r, s;
      logic [3:0]  o, d;
      r = m_known ? mem_result     : 16'h0;
      s = m_known ? mem_store_data : 16'h0;
      o = m_known ? mem_opcode     : 4'h0;
      d = m_known ? mem_rd         : 4'h0;
      return {mem_valid, o, r, s, d, mem_reg_write, mem_mem_read, mem_mem_write,
              flag_n, flag_z, flag_v};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic s, input logic f, input logic v,
                        input logic [3:0] op, input logic [15:0] res, input logic ov,
                        input logic [3:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic [15:0] sd);
      rst_n = r; stall = s; flush = f; ex_valid = v; ex_opcode = op;
      ex_result = res; ex_ovfl = ov; ex_rd = rd; ex_reg_write = rw;
      ex_mem_read = mr; ex_mem_write = mw; ex_store_data = sd;
   endtask

   // One clock: check bypass, advance model, clock, compare registered state.
   task automatic step();
      logic [2:0] nf;
      #1;
      nf = model_next_flags();
      if (rst_n) check("flags_fwd", {61'd0, flags_fwd}, {61'd0, nf});
      if (!rst_n) begin
         m_valid = 0; m_op = 0; m_res = 0; m_sd = 0; m_rd = 0;
         m_rw = 0; m_mr = 0; m_mw = 0; m_flg = 0; m_known = 1;
      end else if (!stall) begin
         m_valid = ex_valid & ~flush;
         m_rw    = ex_reg_write & m_valid;
         m_mr    = ex_mem_read  & m_valid;
         m_mw    = ex_mem_write & m_valid;
         m_op    = ex_opcode; m_res = ex_result; m_sd = ex_store_data; m_rd = ex_rd;
         m_known = ~flush;
         m_flg   = nf;
      end
      exp_q.push_back(model_rec());
      @(posedge clk);
      #1;
      check("mem_rec", {17'd0, dut_rec()}, {17'd0, exp_q.pop_front()});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      m_known = 1; m_flg = 0;
      @(posedge clk); #1;

      // 1. reset with stall and valid asserted
      drive(0, 1, 0, 1, 4'd0, 16'h1234, 1, 4'd5, 1, 1, 1, 16'hBEEF);
      step(); step();
      check("rst_valid", {63'd0, mem_valid}, 64'd0);
      check("rst_ctrl", {61'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 64'd0);
      check("rst_data", {16'd0, mem_result, mem_store_data}, 64'd0);
      check("rst_flags", {61'd0, flag_n, flag_z, flag_v}, 64'd0);

      // 2. ADD 0x8000 with overflow
      drive(1, 0, 0, 1, 4'd0, 16'h8000, 1, 4'd3, 1, 0, 0, 16'h0011);
      #1 check("add_fwd", {61'd0, flags_fwd}, 64'b101);
      step();
      check("add_res", {48'd0, mem_result}, 64'h8000);
      check("add_flags", {61'd0, flag_n, flag_z, flag_v}, 64'b101);

      // 3. XOR zero -> Z set, N/V kept; PADDSB zero -> no change
      drive(1, 0, 0, 1, 4'd2, 16'h0000, 0, 4'd4, 1, 0, 0, 16'h0);
      step();
      check("xor_flags", {61'd0, flag_n, flag_z, flag_v}, 64'b111);
      drive(1, 0, 0, 1, 4'd7, 16'h0000, 0, 4'd4, 1, 0, 0, 16'h0);
      step();
      check("paddsb_flags", {61'd0, flag_n, flag_z, flag_v}, 64'b111);

      // 4. SUB 0x0001 held by stall for 3 cycles
      drive(1, 1, 0, 1, 4'd1, 16'h0001, 0, 4'd6, 1, 0, 0, 16'h0);
      repeat (3) step();
      check("stall_op", {60'd0, mem_opcode}, 64'd7);
      check("stall_flags", {61'd0, flag_n, flag_z, flag_v}, 64'b111);
      stall = 0;
      step();
      check("sub_op", {60'd0, mem_opcode}, 64'd1);
      check("sub_flags", {61'd0, flag_n, flag_z, flag_v}, 64'b000);

      // 5. valid ADD, then stall+flush (hold), then flush alone (bubble)
      drive(1, 0, 0, 1, 4'd0, 16'h8000, 1, 4'd2, 1, 0, 0, 16'h0);
      step();
      drive(1, 1, 1, 1, 4'd0, 16'h0000, 0, 4'd9, 1, 0, 0, 16'h0);
      step();
      check("stfl_valid", {63'd0, mem_valid}, 64'd1);
      check("stfl_rd", {60'd0, mem_rd}, 64'd2);
      stall = 0;
      step();
      check("flush_valid", {62'd0, mem_valid, mem_reg_write}, 64'd0);
      check("flush_flags", {61'd0, flag_n, flag_z, flag_v}, 64'b101);

      // 6. bubble carrying ADD opcode and zero result
      drive(1, 0, 0, 0, 4'd0, 16'h0000, 0, 4'd1, 1, 1, 1, 16'h0);
      step();
      check("bub_ctrl", {60'd0, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write}, 64'd0);
      check("bub_flags", {61'd0, flag_n, flag_z, flag_v}, 64'b101);

      // Randomized traffic, zero results and saturation corners favoured.
      for (int i = 0; i < 400; i++) begin
         logic [15:0] res;
         case ($urandom_range(0, 3))
            0:       res = 16'h0000;
            1:       res = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            default: res = 16'($urandom);
         endcase
         drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 15)), res, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_flag_stage.md
Name: ex_mem_flag_stage

Overview:
EX/MEM boundary stage for the WISC 16-bit pipeline, directly downstream of the ALU / parallel sub-word adder result mux.
- Registers the EX result, destination register and control into the MEM stage.
- Owns the architectural N/Z/V flag register, updated per opcode from the EX result.
- Supplies a same-cycle flag bypass to branch resolution.
- Handles pipeline stall (hold) and flush (bubble insertion).

Parameters:
DATA_W, 16, datapath width; only 16 is supported.
REG_AW, 4, destination register address width.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  hold all stage registers and flags this cycle
flush  input  1  replace incoming instruction with bubble; flags not updated
ex_valid  input  1  EX holds a real instruction
ex_opcode  input  4  EX instruction opcode
ex_result  input  16  ALU/PSA/shifter result, already saturated where applicable
ex_ovfl  input  1  signed overflow from EX adder (ADD/SUB only meaningful)
ex_rd  input  4  destination register
ex_reg_write  input  1  instruction writes register file
ex_mem_read  input  1  load
ex_mem_write  input  1  store
ex_store_data  input  16  store data
mem_valid  output  1  MEM-stage instruction valid
mem_opcode  output  4  registered opcode
mem_result  output  16  registered result / memory address
mem_store_data  output  16  registered store data
mem_rd  output  4  registered destination
mem_reg_write  output  1  qualified by mem_valid
mem_mem_read  output  1  qualified by mem_valid
mem_mem_write  output  1  qualified by mem_valid
flag_n  output  1  registered negative flag
flag_z  output  1  registered zero flag
flag_v  output  1  registered overflow flag
flags_fwd  output  3  {N,Z,V} values that will be registered at end of this cycle (combinational bypass)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. When rst_n=0 at a rising edge:
  - mem_valid, mem_reg_write, mem_mem_read and mem_mem_write are 0.
  - mem_opcode, mem_result, mem_store_data and mem_rd are 0.
  - flag_n, flag_z and flag_v are 0.
  - Reset overrides stall and flush.
- Advance condition: adv = ~stall. Priority is reset > stall > flush > normal.
- stall=1: every register holds, including the flags. flags_fwd equals the current flags.
- flush=1 and stall=0: next mem_valid=0 and all control outputs go to 0. Data registers may load but are don't-care. Flags hold.
- Normal: register every ex_* field. Control bits are ANDed with ex_valid. Latency is 1 cycle.
- A flag update happens only when adv & ~flush & ex_valid:
  - ADD(0000), SUB(0001): N=ex_result[15]; Z=(ex_result==0); V=ex_ovfl.
  - XOR(0010), SLL(0100), SRA(0101), ROR(0110): Z=(ex_result==0); N and V hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): no flag change.
- flags_fwd = the flag update value if the update condition is true, otherwise the current registers. Branch logic in the same cycle uses flags_fwd.
- For ADD/SUB, Z is computed on the saturated result, so 0x7FFF with V=1 gives Z=0.
- A bubble (ex_valid=0) never touches the flags, whatever ex_opcode holds.
- Store data passes through unmodified. No arithmetic is performed on ex_result.

Decomposition:
- Shared package wisc_pkg holds:
  - the opcode localparams: OP_ADD..OP_HLT, 4-bit.
  - the flag index constants: FLG_N=2, FLG_Z=1, FLG_V=0.
  - the function sets_all_flags(op).
  - the function sets_z_only(op).
- One sub-module, flag_reg: 3-bit register with per-bit write enables and synchronous active-low reset. The top-level contains the pipeline register and the flag-update decode.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with ex_valid=1, stall=1 -> all outputs 0, flags 000. Release -> next cycle registers the EX inputs.
2. ADD, result 0x8000, ovfl=1 -> after 1 cycle mem_result=0x8000 and flags N=1, Z=0, V=1. flags_fwd=101 in the issue cycle.
3. XOR result 0x0000 following (2) -> Z=1, N=1 and V=1 retained. Then PADDSB result 0x0000 -> flags unchanged (N=1, Z=1, V=1).
4. Stall: stall=1 for 3 cycles while EX holds SUB result 0x0001 -> mem_* and flags frozen. On stall release, SUB registers with N=0, Z=0, V=0.
5. Flush: flush=1 with ex_valid=1 ADD, ex_reg_write=1 -> mem_valid=0, mem_reg_write=0, flags unchanged. stall=1 & flush=1 together -> full hold, no bubble.
6. Bubble: ex_valid=0, ex_opcode=ADD, ex_result=0 -> flags unchanged, mem_valid=0, all mem control outputs 0.
